alu_issue_unit: RTL

//  Command front-end and result back-end for the registered ALU. Accepts {a,b,sel} commands
//  on a valid/ready port and buffers them in a small FIFO. Issues one op at a time to the
//  ALU's a/b/sel inputs, waits the ALU latency, then captures result into a held

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_cmd_fifo.sv | 69 ++++++
 rtl/alu_issue_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared widths and op-select codes for the registered ALU and
//               its issue unit.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int OP_W  = 4;
    localparam int SEL_W = 2;
    localparam int RES_W = 8;

    localparam logic [SEL_W-1:0] c_sel_add = 2'd0;
    localparam logic [SEL_W-1:0] c_sel_sub = 2'd1;
    localparam logic [SEL_W-1:0] c_sel_and = 2'd2;
    localparam logic [SEL_W-1:0] c_sel_or  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Synchronous FIFO holding {a,b,sel} commands ahead of the ALU.
//               Push is ignored when full and pop is ignored when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // Storage array: written on accepted push only; stale contents are never read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_unit
// Description : Buffers {a,b,sel} commands, issues them one at a time to a
//               registered ALU, waits its latency and holds each result on a
//               valid/ready output until consumed. Results leave in order.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int OP_W    = alu_pkg::OP_W,
    parameter int SEL_W   = alu_pkg::SEL_W,
    parameter int RES_W   = alu_pkg::RES_W,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [OP_W-1:0]            cmd_a,
    input  logic [OP_W-1:0]            cmd_b,
    input  logic [SEL_W-1:0]           cmd_sel,
    output logic [OP_W-1:0]            alu_a,
    output logic [OP_W-1:0]            alu_b,
    output logic [SEL_W-1:0]           alu_sel,
    input  logic [RES_W-1:0]           alu_result,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [RES_W-1:0]           res_data,
    output logic [SEL_W-1:0]           res_sel,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int LAT_W  = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam int FIFO_W = 2 * OP_W + SEL_W;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;

    logic [1:0]        r_state;
    logic [LAT_W-1:0]  r_wait_cnt;
    logic [OP_W-1:0]   r_alu_a;
    logic [OP_W-1:0]   r_alu_b;
    logic [SEL_W-1:0]  r_alu_sel;
    logic              r_res_valid;
    logic [RES_W-1:0]  r_res_data;
    logic [SEL_W-1:0]  r_res_sel;

    logic              w_full;
    logic              w_empty;
    logic              w_issue;
    logic [FIFO_W-1:0] w_head;
    logic [CNT_W-1:0]  w_count;

    // An op leaves the FIFO from IDLE, or from HOLD in the same edge the
    // pending result is consumed, so the ALU never sees two ops in flight.
    assign w_issue = !w_empty &&
                     ((r_state == c_st_idle) ||
                      ((r_state == c_st_hold) && res_ready));

    alu_cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (FIFO_W)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data ({cmd_a, cmd_b, cmd_sel}),
        .pop       (w_issue),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Issue/wait/hold sequencing with registered ALU inputs and result port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_wait_cnt  <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_sel   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_issue) begin
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (r_wait_cnt == '0) begin
                        r_res_data  <= alu_result;
                        r_res_sel   <= r_alu_sel;
                        r_res_valid <= 1'b1;
                        r_state     <= c_st_hold;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - LAT_W'(1);
                    end
                end
                c_st_hold: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= w_issue ? c_st_wait : c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase

            // Head of the FIFO drives the ALU until the next issue
            if (w_issue) begin
                {r_alu_a, r_alu_b, r_alu_sel} <= w_head;
                r_wait_cnt                    <= LAT_W'(ALU_LAT);
            end
        end
    end

    assign cmd_ready = !w_full;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_sel   = r_res_sel;
    assign count     = w_count;
    assign busy      = (r_state != c_st_idle) || (w_count != '0);

endmodule
`default_nettype wire
